// File: rtl/core_defs.sv
// Shared core definitions for the hazard scoreboard: register file geometry,
// load latency limits and the scoreboard entry layout.
package core_defs;

  localparam int unsigned NREG_DEF     = 32;
  localparam int unsigned REG_W        = 5;
  localparam int unsigned LOAD_LAT_DEF = 1;
  localparam int unsigned LOAD_LAT_MAX = 7;
  localparam int unsigned CNT_W_DEF    = 32;
  localparam int unsigned SB_W         = $clog2(LOAD_LAT_MAX + 1);

  // One register's pending-result state: cycles until forwardable, and load origin.
  typedef struct packed {
    logic [SB_W-1:0] cnt;
    logic            ld;
  } sb_entry_t;

endpackage

// File: rtl/reg_countdown.sv
// Single-register countdown entry: loaded on issue of a writer, decremented
// every cycle until it reaches zero.
module reg_countdown
  import core_defs::*;
#(
  parameter int unsigned LAT = LOAD_LAT_DEF
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      set,
  input  logic      load,
  output sb_entry_t entry
);

  // A fresh write from ID takes priority over the ongoing countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      entry <= '0;
    end else if (set) begin
      entry.cnt <= load ? SB_W'(LAT) : '0;
      entry.ld  <= load;
    end else if (entry.cnt != '0) begin
      entry.cnt <= entry.cnt - SB_W'(1);
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// ID/EX hazard unit: per-register countdown scoreboard driving stall/flush.
// Optional mul/div tracking is built when HAZARD_MULDIV_EN is defined.
module hazard_scoreboard
  import core_defs::*;
#(
  parameter int unsigned NREG     = NREG_DEF,
  parameter int unsigned LOAD_LAT = LOAD_LAT_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_reg_write,
  input  logic             id_mem_read,
  input  logic             id_mem_write,
`ifdef HAZARD_MULDIV_EN
  input  logic             id_muldiv,
  input  logic             md_done,
`endif
  input  logic             br_ctrl,
  input  logic             ret_ctrl,
  output logic             stall,
  output logic             flush,
  output logic             issue,
  output logic [CNT_W-1:0] stall_cycles
);

  sb_entry_t sb [NREG];
  logic      wr_en;
  logic      rs1_hit;
  logic      rs2_hit;
  logic      rs2_fwd;
  logic      md_haz;

  assign sb[0] = '0;

  always_comb wr_en = issue & id_reg_write & (id_rd != '0);

  for (genvar r = 1; r < NREG; r++) begin : g_sb
    reg_countdown #(.LAT(LOAD_LAT)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .set   (wr_en && (id_rd == REG_W'(r))),
      .load  (id_mem_read),
      .entry (sb[r])
    );
  end

  // Store data one cycle from a load is covered by MEM->MEM forwarding.
  always_comb begin
    rs1_hit = id_rs1_used && (id_rs1 != '0) && (sb[id_rs1].cnt != '0);
    rs2_hit = id_rs2_used && (id_rs2 != '0) && (sb[id_rs2].cnt != '0);
    rs2_fwd = id_mem_write && sb[id_rs2].ld && (sb[id_rs2].cnt == SB_W'(1));
  end

`ifdef HAZARD_MULDIV_EN
  logic             md_busy;
  logic [REG_W-1:0] md_rd;
  logic             md_live;

  // md_done bypasses the hazard in the same cycle it writes back.
  always_comb begin
    md_live = md_busy & ~md_done;
    md_haz  = md_live & (id_muldiv
                       | (id_rs1_used & (id_rs1 != '0) & (id_rs1 == md_rd))
                       | (id_rs2_used & (id_rs2 != '0) & (id_rs2 == md_rd))
                       | (id_reg_write & (id_rd != '0) & (id_rd == md_rd)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      md_busy <= 1'b0;
      md_rd   <= '0;
    end else if (issue & id_muldiv) begin
      md_busy <= 1'b1;
      md_rd   <= id_rd;
    end else if (md_done) begin
      md_busy <= 1'b0;
    end
  end
`else
  always_comb md_haz = 1'b0;
`endif

  always_comb begin
    flush = rst | br_ctrl | ret_ctrl;
    stall = id_valid & ~flush & (rs1_hit | (rs2_hit & ~rs2_fwd) | md_haz);
    issue = id_valid & ~stall & ~flush;
  end

  // Saturating stall-cycle performance counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (stall && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Randomized bench for hazard_scoreboard against a ready-time reference model
// (LOAD_LAT=3, 4-bit stall counter). Covers mul/div when HAZARD_MULDIV_EN is set.
module tb_hazard_scoreboard;

  localparam int unsigned LAT  = 3;
  localparam int unsigned CW   = 4;
  localparam int unsigned NCYC = 3000;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_rs1_used, id_rs2_used;
  logic          id_reg_write, id_mem_read, id_mem_write;
  logic          id_muldiv, md_done;
  logic          br_ctrl, ret_ctrl;
  logic          stall, flush, issue;
  logic [CW-1:0] stall_cycles;

  always #5 clk = ~clk;

  hazard_scoreboard #(.NREG(32), .LOAD_LAT(LAT), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .id_mem_write (id_mem_write),
`ifdef HAZARD_MULDIV_EN
    .id_muldiv    (id_muldiv),
    .md_done      (md_done),
`endif
    .br_ctrl      (br_ctrl),
    .ret_ctrl     (ret_ctrl),
    .stall        (stall),
    .flush        (flush),
    .issue        (issue),
    .stall_cycles (stall_cycles)
  );

  // Reference model: absolute cycle at which each register becomes forwardable.
  int   ready_at [32];
  bit   is_load  [32];
  int   cyc;
  int   stalls;
  bit   m_busy;
  logic [4:0] m_rd;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      ready_at[r] = 0;
      is_load[r]  = 1'b0;
    end
    stalls = 0;
    m_busy = 1'b0;
    m_rd   = '0;
  endtask

  task automatic drive_random();
    int op;
    rst          = ($urandom_range(0, 99) == 0);
    id_valid     = ($urandom_range(0, 9) != 0);
    id_rs1       = 5'($urandom_range(0, 3));
    id_rs2       = 5'($urandom_range(0, 3));
    id_rd        = 5'($urandom_range(0, 3));
    id_rs1_used  = ($urandom_range(0, 3) != 0);
    id_rs2_used  = ($urandom_range(0, 3) != 0);
    op           = int'($urandom_range(0, 7));
    id_mem_read  = (op < 3);
    id_mem_write = (op == 3);
    id_reg_write = (op < 3) || ((op != 3) && ($urandom_range(0, 7) != 0));
    if (op == 3) id_rs2_used = 1'b1;
`ifdef HAZARD_MULDIV_EN
    id_muldiv    = (op == 4);
    md_done      = m_busy && ($urandom_range(0, 5) == 0);
`else
    id_muldiv    = 1'b0;
    md_done      = 1'b0;
`endif
    br_ctrl      = ($urandom_range(0, 15) == 0);
    ret_ctrl     = ($urandom_range(0, 15) == 0);
  endtask

  initial begin
    bit h1, h2, mh, fe, se, ie;
    int exp_cnt;

    rst = 1'b1; id_valid = 1'b1; id_rs1 = 5'd1; id_rs2 = 5'd2; id_rd = 5'd3;
    id_rs1_used = 1'b1; id_rs2_used = 1'b1; id_reg_write = 1'b1;
    id_mem_read = 1'b1; id_mem_write = 1'b0; id_muldiv = 1'b0; md_done = 1'b0;
    br_ctrl = 1'b0; ret_ctrl = 1'b0;
    cyc = 0;
    model_reset();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_flush", 32'(flush), 32'd1);
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_issue", 32'(issue), 32'd0);
    check_eq("rst_count", 32'(stall_cycles), 32'd0);

    for (int i = 0; i < NCYC; i++) begin
      @(negedge clk);
      drive_random();
      #1;
      h1 = id_rs1_used && (id_rs1 != 0) && (ready_at[id_rs1] > cyc);
      h2 = id_rs2_used && (id_rs2 != 0) && (ready_at[id_rs2] > cyc);
      if (h2 && id_mem_write && is_load[id_rs2] && (ready_at[id_rs2] - cyc == 1)) h2 = 1'b0;
      mh = 1'b0;
`ifdef HAZARD_MULDIV_EN
      if (m_busy && !md_done)
        mh = id_muldiv
          || (id_rs1_used && (id_rs1 != 0) && (id_rs1 == m_rd))
          || (id_rs2_used && (id_rs2 != 0) && (id_rs2 == m_rd))
          || (id_reg_write && (id_rd != 0) && (id_rd == m_rd));
`endif
      fe = rst || br_ctrl || ret_ctrl;
      se = !fe && id_valid && (h1 || h2 || mh);
      ie = id_valid && !se && !fe;
      exp_cnt = (stalls > 15) ? 15 : stalls;

      check_eq("flush", 32'(flush), 32'(fe));
      check_eq("stall", 32'(stall), 32'(se));
      check_eq("issue", 32'(issue), 32'(ie));
      check_eq("stall_cycles", 32'(stall_cycles), 32'(exp_cnt));

      if (rst) begin
        model_reset();
      end else begin
        if (ie && id_reg_write && (id_rd != 0)) begin
          ready_at[id_rd] = id_mem_read ? cyc + int'(LAT) + 1 : cyc + 1;
          is_load[id_rd]  = id_mem_read;
        end
        if (ie && id_muldiv) begin
          m_busy = 1'b1;
          m_rd   = id_rd;
        end else if (md_done) begin
          m_busy = 1'b0;
        end
        if (se) stalls++;
      end
      cyc++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised pipeline hazard unit for the RV32 core: replaces single-cycle load-use detection with a per-register countdown scoreboard, so load latency is configurable and an optional multi-cycle mul/div unit is tracked. Sits between ID and EX, driving the ID/IF stall and the IF/ID, ID/EX flush. Also keeps a saturating stall-cycle performance counter.

## Interface
- NREG, 32: architectural registers; x0 is never tracked.
- LOAD_LAT, 1: cycles after issue before a load result is forwardable; legal range 1..7.
- CNT_W, 32: stall performance counter width.
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  5 each  source registers
- id_rs1_used, id_rs2_used  in  1 each  source actually read
- id_rd  in  5  destination register
- id_reg_write  in  1  instruction writes id_rd
- id_mem_read  in  1  instruction is a load
- id_mem_write  in  1  instruction is a store; rs2 is store data
- id_muldiv  in  1  mul/div op (present only with HAZARD_MULDIV_EN)
- md_done  in  1  mul/div result written back this cycle (HAZARD_MULDIV_EN only)
- br_ctrl, ret_ctrl  in  1 each  taken branch / return resolved in EX
- stall  out  1  hold PC and IF/ID, bubble into ID/EX
- flush  out  1  kill IF/ID and ID/EX contents
- issue  out  1  ID instruction advances this cycle
- stall_cycles  out  CNT_W  count of cycles with stall=1

## Operation
- Scoreboard: per register, counter cnt[r] (3 bits) and load flag ld[r]; all zero after reset.
- issue = id_valid & ~stall & ~flush.
- On issue with id_reg_write and id_rd≠0: id_mem_read → cnt=LOAD_LAT, ld=1; otherwise cnt=0, ld=0 (ALU results fully forwarded).
- Each cycle every nonzero cnt decrements by 1; a same-cycle issue write to that register wins over the decrement.
- Source hit: id_rsN_used, id_rsN≠0, cnt[id_rsN]≠0.
- Store exception: if id_mem_write, rs2 hit only, cnt[rs2]==1 and ld[rs2]==1, the rs2 hit is ignored (MEM→MEM data forwarding). An rs1 hit still stalls.
- flush = br_ctrl | ret_ctrl. When flush=1, stall is forced to 0 and the ID instruction is discarded (no scoreboard write).
- stall = id_valid & ~flush & (any unexcepted source hit | mul/div hazard).
- stall_cycles increments on every stall=1 cycle and saturates at all-ones (no wrap).

## Timing
- stall, flush, issue: combinational from current state and inputs. Scoreboard and counter update on rising clk.
- LOAD_LAT=1: a load issued at cycle t stalls a dependent instruction in ID at t+1. The dependent issues at t+2. Store-data dependence issues at t+1.
- LOAD_LAT=3: the dependent stalls at t+1..t+3 and issues at t+4.
- rst mid-operation: all cnt, ld, mul/div state and stall_cycles are cleared the next edge. While rst=1, stall=0 and flush=1.

## Configuration
- HAZARD_MULDIV_EN defined: id_muldiv and md_done ports exist. A register md_busy/md_rd is set on issue of id_muldiv and cleared on md_done. While md_busy:
  - stall on any id_muldiv (structural hazard);
  - stall on a source hit on md_rd (RAW);
  - stall on id_reg_write to md_rd (WAW).
  - md_done in the same cycle removes these hazards combinationally (bypass). md_done and a new issue of id_muldiv in the same cycle leaves md_busy=1 with the new rd.
- Not defined: ports absent, md logic removed, and behaviour is identical to load-only scoreboard.

## Structure
- Shared package/header `core_defs`: NREG, register-index width, LOAD_LAT default and maximum, CNT_W.
- One sub-module, `reg_countdown`: a single register's cnt/ld pair with set, decrement and clear, instantiated NREG-1 times.

## Test plan
- LOAD_LAT=1: lw x5 then add x6,x5,x1 → stall=1 for one cycle, issue of add at t+2, stall_cycles=1.
- LOAD_LAT=1: lw x5 then sw x5,0(x2) → no stall. sw x1,0(x5) → one-cycle stall.
- LOAD_LAT=3: lw x7 then add using x7 → stall for exactly 3 cycles. Add using x0 after lw x0 → no stall.
- br_ctrl=1 while a load-use is pending in ID → flush=1, stall=0, scoreboard unchanged by the killed instruction.
- HAZARD_MULDIV_EN: div x9 issues, md_done after 8 cycles. A following mul stalls until the md_done cycle and issues in it. add x9 (WAW) stalls identically.
- Force stall for 2^CNT_W+ cycles (CNT_W=4 build) → stall_cycles holds 15. rst mid-stall clears cnt and the counter to 0 the next cycle.
